// File: rtl/closest_hit_reducer_pkg.sv
// ============================================================================
// closest_hit_reducer_pkg : shared types/constants for the closest-hit reducer
// Revision 1.0
// ============================================================================
`default_nettype none

package closest_hit_reducer_pkg;

  localparam int unsigned MAX_SHAPES_DEF = 16;
  localparam int unsigned SIDX_W         = $clog2(MAX_SHAPES_DEF);

  typedef logic [SIDX_W-1:0] shape_idx_t;

  localparam logic [15:0] F16_POS_INF = 16'h7C00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic        hit;
    shape_idx_t  idx;
    logic [15:0] sq_dist;
    logic [47:0] isect;
  } hit_record_t;

  // Nonnegative and not NaN; +inf counts as a number.
  function automatic logic f16_is_pos_num(input logic [15:0] x);
    return !x[15] && !((x[14:10] == 5'h1F) && (x[9:0] != 10'd0));
  endfunction

endpackage

`default_nettype wire

// File: rtl/closest_hit_reducer_lt.sv
// ============================================================================
// float16_pos_less_than : combinational a<b over nonnegative float16, NaN flag
// Revision 1.0
// ============================================================================
`default_nettype none

module float16_pos_less_than (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        lt_o,
  output logic        nan_o
);

  logic w_a_nan;
  logic w_b_nan;

  assign w_a_nan = (a_i[14:10] == 5'h1F) && (a_i[9:0] != 10'd0);
  assign w_b_nan = (b_i[14:10] == 5'h1F) && (b_i[9:0] != 10'd0);

  // With both sign bits clear, the raw bit pattern is monotonic in value.
  assign lt_o  = a_i < b_i;
  assign nan_o = w_a_nan | w_b_nan;

endmodule

`default_nettype wire

// File: rtl/closest_hit_reducer.sv
// ============================================================================
// closest_hit_reducer : per-ray nearest positive hit; optional CLOSEST_HIT_EPS_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module closest_hit_reducer
  import closest_hit_reducer_pkg::*;
#(
  parameter int unsigned MAX_SHAPES  = MAX_SHAPES_DEF,
  parameter logic [15:0] MIN_SQ_DIST = 16'h1400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic [SIDX_W:0]   num_shapes,
  input  logic              valid_in,
  input  logic              hit_in,
  input  logic [15:0]       sq_dist_in,
  input  logic [47:0]       isect_in,
  output logic              valid_out,
  output logic              ray_hit,
  output logic [SIDX_W-1:0] shape_idx,
  output logic [15:0]       sq_distance,
  output logic [47:0]       intersection,
  output logic              busy
);

`ifdef CLOSEST_HIT_EPS_EN
  localparam logic c_eps_en = 1'b1;
`else
  localparam logic c_eps_en = 1'b0;
`endif

  localparam logic [SIDX_W:0] c_one   = {{SIDX_W{1'b0}}, 1'b1};
  localparam logic [SIDX_W:0] c_max_n = MAX_SHAPES[SIDX_W:0];
  localparam hit_record_t     c_empty = '{hit: 1'b0, idx: '0, sq_dist: F16_POS_INF, isect: '0};

  state_t          state_q, state_d;
  logic [SIDX_W:0] count_q, count_d;
  logic [SIDX_W:0] n_q, n_d;
  hit_record_t     best_q, best_d;
  hit_record_t     out_q, out_d;
  logic            valid_q, valid_d;

  logic            w_above_min;
  logic            w_accept;
  logic            w_lt;
  logic            w_nan;
  logic            w_replace;
  logic [SIDX_W:0] w_n_req;
  logic [SIDX_W:0] w_n;
  hit_record_t     w_cand;
  hit_record_t     w_merge;

  float16_pos_less_than u_lt (
    .a_i   (sq_dist_in),
    .b_i   (best_q.sq_dist),
    .lt_o  (w_lt),
    .nan_o (w_nan)
  );

  assign w_above_min = sq_dist_in[14:0] >= MIN_SQ_DIST[14:0];
  assign w_accept    = hit_in && f16_is_pos_num(sq_dist_in) && (w_above_min || !c_eps_en);

  assign w_n_req = (num_shapes == '0) ? c_one : num_shapes;
  assign w_n     = (w_n_req > c_max_n) ? c_max_n : w_n_req;

  always_comb begin
    w_cand         = c_empty;
    w_cand.idx     = (state_q == ST_ACCUM) ? count_q[SIDX_W-1:0] : '0;
    if (w_accept) begin
      w_cand.hit     = 1'b1;
      w_cand.sq_dist = sq_dist_in;
      w_cand.isect   = isect_in;
    end
  end

  // Strict less-than keeps the lower index on ties; a miss-only best is always replaced.
  assign w_replace = w_accept && (!best_q.hit || (w_lt && !w_nan));
  assign w_merge   = w_replace ? w_cand : best_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    n_d     = n_q;
    best_d  = best_q;
    out_d   = out_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_in && !abort) begin
          best_d = w_cand;
          n_d    = w_n;
          if (w_n == c_one) begin
            out_d   = w_cand;
            valid_d = 1'b1;
          end else begin
            state_d = ST_ACCUM;
            count_d = c_one;
          end
        end
      end
      ST_ACCUM: begin
        if (abort) begin
          state_d = ST_IDLE;
          count_d = '0;
          best_d  = c_empty;
        end else if (valid_in) begin
          best_d = w_merge;
          if (count_q == n_q - c_one) begin
            out_d   = w_merge;
            valid_d = 1'b1;
            state_d = ST_IDLE;
            count_d = '0;
          end else begin
            count_d = count_q + c_one;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      n_q     <= c_one;
      best_q  <= c_empty;
      out_q   <= c_empty;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      n_q     <= n_d;
      best_q  <= best_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign valid_out    = valid_q;
  assign ray_hit      = out_q.hit;
  assign shape_idx    = out_q.idx;
  assign sq_distance  = out_q.sq_dist;
  assign intersection = out_q.isect;
  assign busy         = (state_q == ST_ACCUM);

endmodule

`default_nettype wire
